// File: rtl/data_memory_hs.sv
// data_memory_hs: handshaked word RAM with byte lanes, wait states and fault flagging.
// Define DMEM_STATS_EN to add saturating read/write/error counters.
module data_memory_hs #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic                    i_req_valid,
    output logic                    o_req_ready,
    input  logic                    i_rw,
    input  logic [ADDR_WIDTH-1:0]   i_address,
    input  logic [DATA_WIDTH-1:0]   i_data,
    input  logic [DATA_WIDTH/8-1:0] i_byte_write_lines,
    output logic                    o_resp_valid,
    input  logic                    i_resp_ready,
    output logic [DATA_WIDTH-1:0]   o_data,
    output logic                    o_error,
    output logic                    o_busy
`ifdef DMEM_STATS_EN
    ,
    output logic [31:0]             o_read_count,
    output logic [31:0]             o_write_count,
    output logic [31:0]             o_error_count
`endif
);
    localparam int LANES = DATA_WIDTH / 8;
    localparam int LSB = $clog2(LANES);
    localparam int IW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
    localparam int CW = WAIT_STATES > 1 ? $clog2(WAIT_STATES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

    state_t state, state_next;
    logic [CW-1:0] cnt;
    logic rw;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [LANES-1:0] lanes;
    logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];
    logic [ADDR_WIDTH-1:0] widx;
    logic [IW-1:0] idx;
    logic fault;

    assign widx = addr >> LSB;
    assign idx = widx[IW-1:0];
    // Compare at 64 bits so a depth of 2**ADDR_WIDTH words does not wrap to zero.
    assign fault = (addr & ADDR_WIDTH'((1 << LSB) - 1)) != '0 || 64'(widx) >= 64'(DEPTH_WORDS);

    always_comb begin
        state_next = state;
        o_req_ready = state == S_IDLE;
        o_resp_valid = state == S_RESP;
        o_busy = state != S_IDLE;
        case (state)
            S_IDLE:   state_next = i_req_valid ? (WAIT_STATES > 0 ? S_WAIT : S_ACCESS) : S_IDLE;
            S_WAIT:   state_next = cnt == CW'(WAIT_STATES - 1) ? S_ACCESS : S_WAIT;
            S_ACCESS: state_next = S_RESP;
            default:  state_next = i_resp_ready ? S_IDLE : S_RESP;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state <= S_IDLE;
            cnt <= '0;
            o_data <= '0;
            o_error <= 1'b0;
        end else begin
            state <= state_next;
            cnt <= (state == S_WAIT && state_next == S_WAIT) ? cnt + CW'(1) : '0;
            if (state == S_IDLE && i_req_valid) begin
                rw <= i_rw;
                addr <= i_address;
                wdata <= i_data;
                lanes <= i_byte_write_lines;
            end
            if (state == S_ACCESS) begin
                o_data <= (!rw && !fault) ? mem[idx] : '0;
                o_error <= fault;
            end
        end
    end

    // Storage has no reset; reset on the access edge still blocks the write.
    always_ff @(posedge i_clock) begin
        if (!i_reset && state == S_ACCESS && rw && !fault)
            for (int k = 0; k < LANES; k++)
                if (lanes[k]) mem[idx][8*k +: 8] <= wdata[8*k +: 8];
    end

`ifdef DMEM_STATS_EN
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            o_read_count <= '0;
            o_write_count <= '0;
            o_error_count <= '0;
        end else if (state == S_RESP && i_resp_ready) begin
            if (o_error) o_error_count <= o_error_count + 32'(o_error_count != '1);
            else if (rw) o_write_count <= o_write_count + 32'(o_write_count != '1);
            else o_read_count <= o_read_count + 32'(o_read_count != '1);
        end
    end
`endif
endmodule

// File: tb/tb_data_memory_hs.sv
// tb_data_memory_hs: directed stimulus on a 1-wait-state and a 0-wait-state instance,
// checked every cycle against a transaction-level model plus literal expectations.
module tb_data_memory_hs;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic req_valid [2], req_ready [2], rw [2], resp_valid [2], resp_ready [2], error [2], busy [2];
    logic [31:0] addr [2], wdata [2], rdata [2];
    logic [3:0] lanes [2];
`ifdef DMEM_STATS_EN
    logic [31:0] rd_cnt, wr_cnt, er_cnt, rd_cnt1, wr_cnt1, er_cnt1;
`endif

    data_memory_hs #(.WAIT_STATES(1)) u0 (
        .i_clock(clk), .i_reset(rst), .i_req_valid(req_valid[0]), .o_req_ready(req_ready[0]),
        .i_rw(rw[0]), .i_address(addr[0]), .i_data(wdata[0]), .i_byte_write_lines(lanes[0]),
        .o_resp_valid(resp_valid[0]), .i_resp_ready(resp_ready[0]), .o_data(rdata[0]),
        .o_error(error[0]), .o_busy(busy[0])
`ifdef DMEM_STATS_EN
        , .o_read_count(rd_cnt), .o_write_count(wr_cnt), .o_error_count(er_cnt)
`endif
    );

    data_memory_hs #(.WAIT_STATES(0)) u1 (
        .i_clock(clk), .i_reset(rst), .i_req_valid(req_valid[1]), .o_req_ready(req_ready[1]),
        .i_rw(rw[1]), .i_address(addr[1]), .i_data(wdata[1]), .i_byte_write_lines(lanes[1]),
        .o_resp_valid(resp_valid[1]), .i_resp_ready(resp_ready[1]), .o_data(rdata[1]),
        .o_error(error[1]), .o_busy(busy[1])
`ifdef DMEM_STATS_EN
        , .o_read_count(rd_cnt1), .o_write_count(wr_cnt1), .o_error_count(er_cnt1)
`endif
    );

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic int ws(input int i);
        return (i == 0) ? 1 : 0;
    endfunction

    function automatic bit is_fault(input logic [31:0] a);
        return a[1:0] != 2'b00 || (a >> 2) >= 32'd1024;
    endfunction

    // Model: 'since' counts edges after acceptance (-1 idle); the response is
    // resolved on the edge that ends the access cycle, i.e. when since reaches ws+1.
    int since [2] = '{-1, -1};
    logic m_rw [2];
    logic [31:0] m_addr [2], m_data [2], exp_data [2];
    logic [3:0] m_lanes [2];
    logic exp_err [2], exp_known [2];
    bit [31:0] mm [2][1024];
    bit [3:0] known [2][1024];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) since[i] <= -1;
            else if (since[i] < 0) begin
                if (req_valid[i]) begin
                    since[i] <= 0;
                    m_rw[i] <= rw[i];
                    m_addr[i] <= addr[i];
                    m_data[i] <= wdata[i];
                    m_lanes[i] <= lanes[i];
                end
            end else if (since[i] <= ws(i)) begin
                since[i] <= since[i] + 1;
                if (since[i] == ws(i)) begin
                    exp_err[i] <= is_fault(m_addr[i]);
                    if (is_fault(m_addr[i]) || m_rw[i]) begin
                        exp_data[i] <= 32'h0;
                        exp_known[i] <= 1'b1;
                    end else begin
                        exp_data[i] <= mm[i][m_addr[i][11:2]];
                        exp_known[i] <= known[i][m_addr[i][11:2]] == 4'hF;
                    end
                    if (!is_fault(m_addr[i]) && m_rw[i])
                        for (int k = 0; k < 4; k++)
                            if (m_lanes[i][k]) begin
                                mm[i][m_addr[i][11:2]][8*k +: 8] <= m_data[i][8*k +: 8];
                                known[i][m_addr[i][11:2]][k] <= 1'b1;
                            end
                end
            end else if (resp_ready[i]) since[i] <= -1;
        end
    end

    always @(negedge clk) begin
        if (check_en)
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("u%0d req_ready", i), req_ready[i], since[i] < 0);
                chk($sformatf("u%0d busy", i), busy[i], since[i] >= 0);
                chk($sformatf("u%0d resp_valid", i), resp_valid[i], since[i] == ws(i) + 1);
                if (since[i] == ws(i) + 1) begin
                    chk($sformatf("u%0d error", i), error[i], exp_err[i]);
                    if (exp_known[i]) chk($sformatf("u%0d data", i), rdata[i], exp_data[i]);
                end
            end
    end

    task automatic accept(input int i, input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] l);
        int n = 0;
        @(negedge clk);
        req_valid[i] = 1'b1; rw[i] = w; addr[i] = a; wdata[i] = d; lanes[i] = l;
        while (!req_ready[i] && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("accept_timeout", req_ready[i], 1'b1);
        @(posedge clk);
        #1 req_valid[i] = 1'b0;
    endtask

    // lat counts edges from the acceptance edge (inclusive) to the one raising o_resp_valid.
    task automatic get_resp(input int i, output logic [31:0] d, output logic e, output int lat);
        lat = 1;
        @(negedge clk);
        while (!resp_valid[i] && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        chk("resp_timeout", resp_valid[i], 1'b1);
        d = rdata[i];
        e = error[i];
    endtask

    task automatic txn(input int i, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] l, output logic [31:0] rd, output logic e, output int lat);
        accept(i, w, a, d, l);
        get_resp(i, rd, e, lat);
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [31:0] d;
    logic e;
    int lat;

    initial begin
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0; rw[i] = 1'b0; addr[i] = '0; wdata[i] = '0; lanes[i] = '0;
            resp_ready[i] = 1'b1;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            chk("reset o_data", rdata[i], 32'h0);
            chk("reset o_error", error[i], 1'b0);
            chk("reset o_req_ready", req_ready[i], 1'b1);
            chk("reset o_busy", busy[i], 1'b0);
            chk("reset o_resp_valid", resp_valid[i], 1'b0);
        end

        txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, d, e, lat);
        chk("write 0x10 error", e, 1'b0);
        txn(0, 1'b0, 32'h10, 32'h0, 4'h0, d, e, lat);
        chk("read 0x10 latency", lat, 3);
        chk("read 0x10 data", d, 32'hDEADBEEF);
        chk("read 0x10 error", e, 1'b0);

        txn(0, 1'b1, 32'h20, 32'h11223344, 4'hF, d, e, lat);
        txn(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, d, e, lat);
        txn(0, 1'b0, 32'h20, 32'h0, 4'h0, d, e, lat);
        chk("partial lanes data", d, 32'h11BB33DD);

        txn(0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, d, e, lat);
        chk("no-lane write error", e, 1'b0);
        txn(0, 1'b0, 32'h10, 32'h0, 4'h0, d, e, lat);
        chk("no-lane write kept", d, 32'hDEADBEEF);

        txn(0, 1'b1, 32'h0, 32'h0BADF00D, 4'hF, d, e, lat);
        txn(0, 1'b0, 32'h22, 32'h0, 4'h0, d, e, lat);
        chk("misaligned error", e, 1'b1);
        chk("misaligned data", d, 32'h0);
        txn(0, 1'b0, 32'h1000, 32'h0, 4'h0, d, e, lat);
        chk("range error", e, 1'b1);
        chk("range data", d, 32'h0);
        txn(0, 1'b1, 32'h1000, 32'h99999999, 4'hF, d, e, lat);
        chk("range write error", e, 1'b1);
        txn(0, 1'b0, 32'h0, 32'h0, 4'h0, d, e, lat);
        chk("word 0 intact", d, 32'h0BADF00D);

        resp_ready[0] = 1'b0;
        accept(0, 1'b0, 32'h20, 32'h0, 4'h0);
        get_resp(0, d, e, lat);
        req_valid[0] = 1'b1; rw[0] = 1'b1; addr[0] = 32'h30; wdata[0] = 32'h12345678; lanes[0] = 4'hF;
        repeat (5) begin
            @(negedge clk);
            chk("stall resp_valid", resp_valid[0], 1'b1);
            chk("stall data", rdata[0], 32'h11BB33DD);
            chk("stall error", error[0], 1'b0);
            chk("stall req_ready", req_ready[0], 1'b0);
        end
        resp_ready[0] = 1'b1;
        @(posedge clk);
        #1 chk("post-handshake idle", busy[0], 1'b0);
        @(posedge clk);
        #1 chk("held request accepted", busy[0], 1'b1);
        req_valid[0] = 1'b0;
        get_resp(0, d, e, lat);
        @(posedge clk);
        #1;
        txn(0, 1'b0, 32'h30, 32'h0, 4'h0, d, e, lat);
        chk("held write landed", d, 32'h12345678);

        for (int i = 0; i < 2; i++) begin
            txn(i, 1'b1, 32'h40, 32'hCAFEF00D, 4'hF, d, e, lat);
            chk("preload latency", lat, ws(i) + 2);
            accept(i, 1'b1, 32'h40, 32'h55, 4'hF);
            reset_pulse();
            chk("mid-op reset o_data", rdata[i], 32'h0);
            chk("mid-op reset o_error", error[i], 1'b0);
            chk("mid-op reset o_req_ready", req_ready[i], 1'b1);
            chk("mid-op reset o_busy", busy[i], 1'b0);
            chk("mid-op reset o_resp_valid", resp_valid[i], 1'b0);
            txn(i, 1'b0, 32'h40, 32'h0, 4'h0, d, e, lat);
            chk("dropped write", d, 32'hCAFEF00D);
        end

`ifdef DMEM_STATS_EN
        reset_pulse();
        txn(0, 1'b0, 32'h10, 32'h0, 4'h0, d, e, lat);
        txn(0, 1'b1, 32'h50, 32'h1, 4'hF, d, e, lat);
        txn(0, 1'b0, 32'h20, 32'h0, 4'h0, d, e, lat);
        txn(0, 1'b1, 32'h54, 32'h2, 4'hF, d, e, lat);
        txn(0, 1'b0, 32'h1002, 32'h0, 4'h0, d, e, lat);
        txn(0, 1'b0, 32'h0, 32'h0, 4'h0, d, e, lat);
        chk("read count", rd_cnt, 32'd3);
        chk("write count", wr_cnt, 32'd2);
        chk("error count", er_cnt, 32'd1);
        reset_pulse();
        chk("read count clear", rd_cnt, 32'd0);
        chk("write count clear", wr_cnt, 32'd0);
        chk("error count clear", er_cnt, 32'd0);
`endif

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
